// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the TDC coarse counter.
// Optional macro TDC_HALF_CYCLE_EN appends the synchronizer phase bit to the result.
package tdc_pkg;

  localparam int unsigned CNT_W_DEF   = 12;
  localparam int unsigned MAX_CNT_DEF = 4095;

`ifdef TDC_HALF_CYCLE_EN
  localparam int unsigned HALF_W = 1;
`else
  localparam int unsigned HALF_W = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } tdc_state_e;

endpackage

// File: rtl/tdc_coarse_cnt_if.sv
// Result handshake between the coarse counter (master) and its consumer (slave).
interface tdc_coarse_cnt_if #(
  parameter int unsigned OUT_W = tdc_pkg::CNT_W_DEF + tdc_pkg::HALF_W
);

  logic [OUT_W-1:0] cnt_out;
  logic             cnt_valid;
  logic             cnt_ready;
  logic             timeout;

  modport master (
    output cnt_out,
    output cnt_valid,
    output timeout,
    input  cnt_ready
  );

  modport slave (
    input  cnt_out,
    input  cnt_valid,
    input  timeout,
    output cnt_ready
  );

endinterface

// File: rtl/tdc_edge_det.sv
// Rising-edge detector on the synchronized stop level: one history flop plus compare.
module tdc_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise_c
);

  logic r_sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise_c = i_sig & ~r_sig_d;

endmodule

// File: rtl/tdc_coarse_cnt.sv
// Coarse TDC counter: counts sync_clk_i edges from start to stop rise, saturates at MAX_CNT.
// Optional macro TDC_HALF_CYCLE_EN widens cnt_out by the phase bit s captured at the stop.
module tdc_coarse_cnt
  import tdc_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_CNT = MAX_CNT_DEF
) (
  input  logic                    sync_clk_i,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sync_in,
  input  logic                    s,
  output logic                    busy,
  tdc_coarse_cnt_if.master        res_if
);

  localparam int unsigned OUT_W = CNT_W + HALF_W;

  tdc_state_e         r_state;
  tdc_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OUT_W-1:0]   r_res;
  logic [OUT_W-1:0]   w_res_nxt;
  logic               r_tmo;
  logic               w_tmo_nxt;
  logic               r_busy;
  logic               r_valid;
  logic               w_rise;
  logic [OUT_W-1:0]   w_cap;
  logic               w_at_max;

  tdc_edge_det u_edge_det (
    .clk      (sync_clk_i),
    .rst_n    (rst_n),
    .i_sig    (sync_in),
    .o_rise_c (w_rise)
  );

`ifdef TDC_HALF_CYCLE_EN
  assign w_cap = {r_cnt, s};
`else
  logic w_unused_s;
  assign w_unused_s = s;
  assign w_cap      = r_cnt;
`endif

  assign w_at_max = (r_cnt == CNT_W'(MAX_CNT));

  // Next-state and datapath: stop rise beats restart and timeout; HOLD ignores start/rise.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_tmo_nxt   = r_tmo;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (w_rise) begin
          w_res_nxt   = w_cap;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = S_HOLD;
        end else if (start) begin
          w_cnt_nxt   = '0;
        end else if (w_at_max) begin
          w_res_nxt   = '1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (res_if.cnt_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sync_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_res   <= '0;
      r_tmo   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_tmo   <= w_tmo_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_valid <= (w_state_nxt == S_HOLD);
    end
  end

  assign busy             = r_busy;
  assign res_if.cnt_out   = r_res;
  assign res_if.cnt_valid = r_valid;
  assign res_if.timeout   = r_tmo;

endmodule

// File: tb/tb_tdc_coarse_cnt.sv
// Directed bench for tdc_coarse_cnt (MAX_CNT=15 so the timeout path is reachable quickly).
module tb_tdc_coarse_cnt;
  import tdc_pkg::*;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned MAX_CNT = 15;
  localparam int unsigned OUT_W   = CNT_W + HALF_W;

  logic sync_clk_i = 1'b0;
  logic rst_n      = 1'b1;
  logic start      = 1'b0;
  logic sync_in    = 1'b0;
  logic s_sel      = 1'b0;
  logic busy;

  int checks   = 0;
  int failures = 0;

  tdc_coarse_cnt_if #(.OUT_W(OUT_W)) res_if ();

  tdc_coarse_cnt #(.CNT_W(CNT_W), .MAX_CNT(MAX_CNT)) dut (
    .sync_clk_i (sync_clk_i),
    .rst_n      (rst_n),
    .start      (start),
    .sync_in    (sync_in),
    .s          (s_sel),
    .busy       (busy),
    .res_if     (res_if)
  );

  always #5 sync_clk_i = ~sync_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_res(input int unsigned c, input logic sv);
`ifdef TDC_HALF_CYCLE_EN
    return 32'((c << 1) | 32'(sv));
`else
    return 32'(c + 0 * 32'(sv));
`endif
  endfunction

  function automatic logic [31:0] exp_tmo_res();
    return 32'((64'd1 << OUT_W) - 64'd1);
  endfunction

  task automatic step();
    @(posedge sync_clk_i);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    res_if.cnt_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_cnt_out", 32'(res_if.cnt_out), 32'd0);
    chk("reset_valid",   32'(res_if.cnt_valid), 32'd0);
    chk("reset_timeout", 32'(res_if.timeout), 32'd0);
    chk("reset_busy",    32'(busy), 32'd0);
    steps(2);
    rst_n = 1'b1;
    steps(2);

    // Basic measurement: start at edge 0, stop sampled at edge 6 -> 5
    start = 1'b1; step();
    start = 1'b0;
    chk("basic_busy", 32'(busy), 32'd1);
    steps(5);
    chk("basic_no_valid", 32'(res_if.cnt_valid), 32'd0);
    sync_in = 1'b1; s_sel = 1'b1; step();
    chk("basic_valid", 32'(res_if.cnt_valid), 32'd1);
    chk("basic_cnt",   32'(res_if.cnt_out), exp_res(5, 1'b1));
    chk("basic_tmo",   32'(res_if.timeout), 32'd0);
    chk("basic_busy_hold", 32'(busy), 32'd0);
    s_sel = 1'b0; step();
    chk("basic_valid_drop", 32'(res_if.cnt_valid), 32'd0);
    sync_in = 1'b0; steps(2);

    // HOLD stays put while consumer stalls, regardless of start/sync_in
    res_if.cnt_ready = 1'b0;
    start = 1'b1; step();
    start = 1'b0; steps(2);
    sync_in = 1'b1; step();
    chk("hold_entry_cnt", 32'(res_if.cnt_out), exp_res(2, 1'b0));
    for (int i = 0; i < 10; i++) begin
      start   = ~start;
      sync_in = ~sync_in;
      step();
      chk("hold_valid", 32'(res_if.cnt_valid), 32'd1);
      chk("hold_cnt",   32'(res_if.cnt_out), exp_res(2, 1'b0));
      chk("hold_tmo",   32'(res_if.timeout), 32'd0);
      chk("hold_busy",  32'(busy), 32'd0);
    end
    start = 1'b0; sync_in = 1'b0;
    res_if.cnt_ready = 1'b1; step();
    chk("hold_release", 32'(res_if.cnt_valid), 32'd0);
    steps(2);

    // Restart at count 3, stop 4 edges after restart -> 3
    start = 1'b1; step();
    start = 1'b0; steps(3);
    start = 1'b1; step();
    start = 1'b0; steps(3);
    sync_in = 1'b1; step();
    chk("restart_valid", 32'(res_if.cnt_valid), 32'd1);
    chk("restart_cnt",   32'(res_if.cnt_out), exp_res(3, 1'b0));
    step();
    sync_in = 1'b0; steps(2);

    // Timeout: no stop for 16 RUN edges
    start = 1'b1; step();
    start = 1'b0; steps(15);
    chk("tmo_not_yet", 32'(res_if.cnt_valid), 32'd0);
    chk("tmo_busy",    32'(busy), 32'd1);
    step();
    chk("tmo_valid", 32'(res_if.cnt_valid), 32'd1);
    chk("tmo_flag",  32'(res_if.timeout), 32'd1);
    chk("tmo_cnt",   32'(res_if.cnt_out), exp_tmo_res());
    steps(2);

    // Stop coincident with counter == MAX_CNT: stop wins
    start = 1'b1; step();
    start = 1'b0; steps(15);
    sync_in = 1'b1; step();
    chk("max_rise_valid", 32'(res_if.cnt_valid), 32'd1);
    chk("max_rise_tmo",   32'(res_if.timeout), 32'd0);
    chk("max_rise_cnt",   32'(res_if.cnt_out), exp_res(15, 1'b0));
    step();
    sync_in = 1'b0; steps(2);

    // Stop and restart at the same edge in RUN: stop wins
    start = 1'b1; step();
    start = 1'b0; step();
    start = 1'b1; sync_in = 1'b1; step();
    start = 1'b0;
    chk("coinc_valid", 32'(res_if.cnt_valid), 32'd1);
    chk("coinc_cnt",   32'(res_if.cnt_out), exp_res(1, 1'b0));
    step();
    sync_in = 1'b0; steps(2);

    // Stop level rising with start, then held high: not a stop until fall+rise
    start = 1'b1; sync_in = 1'b1; step();
    start = 1'b0;
    chk("lvl_busy", 32'(busy), 32'd1);
    steps(3);
    chk("lvl_no_valid", 32'(res_if.cnt_valid), 32'd0);
    sync_in = 1'b0; step();
    sync_in = 1'b1; step();
    chk("lvl_valid", 32'(res_if.cnt_valid), 32'd1);
    chk("lvl_cnt",   32'(res_if.cnt_out), exp_res(4, 1'b0));
    step();
    sync_in = 1'b0; steps(2);

    // Asynchronous reset mid-RUN discards the measurement
    start = 1'b1; step();
    start = 1'b0; steps(3);
    rst_n = 1'b0; #1;
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_valid",   32'(res_if.cnt_valid), 32'd0);
    chk("rst_cnt_out", 32'(res_if.cnt_out), 32'd0);
    chk("rst_tmo",     32'(res_if.timeout), 32'd0);
    step();
    rst_n = 1'b1; step();
    sync_in = 1'b1; steps(3);
    chk("rst_after_valid", 32'(res_if.cnt_valid), 32'd0);
    chk("rst_after_busy",  32'(busy), 32'd0);
    sync_in = 1'b0; steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_coarse_cnt.md
TDC_COARSE_CNT -- requirements
Module: tdc_coarse_cnt

Interface
REQ-001 SHALL have parameter CNT_W, default 12: coarse counter width in bits.
REQ-002 SHALL have parameter MAX_CNT, default 4095: timeout count, at most 2^CNT_W-1.
REQ-003 SHALL have port sync_clk_i  input  1  sampling clock, rising edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  arm/restart request, sampled each edge.
REQ-006 SHALL have port sync_in  input  1  synchronized stop level from the trigger synchronizer.
REQ-007 SHALL have port s  input  1  phase select the synchronizer applied to the current stop.
REQ-008 SHALL have port cnt_out  output  CNT_W (CNT_W+1 with TDC_HALF_CYCLE_EN)  captured coarse result.
REQ-009 SHALL have port cnt_valid  output  1  result available.
REQ-010 SHALL have port cnt_ready  input  1  consumer accepts result.
REQ-011 SHALL have port timeout  output  1  current result is a timeout; qualified by cnt_valid.
REQ-012 SHALL have port busy  output  1  high in RUN state.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and HOLD.
REQ-014 SHALL register sync_in every edge into sync_d; rise = sync_in & ~sync_d.
REQ-015 IDLE: start=1 at an edge -> RUN, counter cleared to 0; a rise at the same edge is ignored.
REQ-016 RUN, rise at an edge -> result <= counter value before that edge, timeout <= 0, state -> HOLD.
REQ-017 RUN, no rise: counter == MAX_CNT -> result all ones, timeout <= 1, state -> HOLD; otherwise counter +1.
REQ-018 RUN, rise coincident with counter == MAX_CNT -> rise wins (result = MAX_CNT, timeout=0).
REQ-019 RUN, start=1 without rise -> counter cleared to 0 and state stays RUN; if rise and start coincide, rise wins.
REQ-020 HOLD: cnt_valid=1 with cnt_out and timeout held stable until cnt_valid & cnt_ready at an edge, then -> IDLE.
REQ-021 HOLD SHALL ignore start and rise.
REQ-022 Latency: sync_in first sampled high at edge n (sync_d=0) -> cnt_valid high after edge n.
REQ-023 sync_in already high when RUN is entered SHALL NOT count as a rise; a fall then rise is required.
REQ-024 cnt_valid SHALL be 1 exactly in HOLD; busy SHALL be 1 exactly in RUN.
REQ-025 The counter SHALL never wrap; it saturates at MAX_CNT via REQ-017.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, counter 0, sync_d 0, cnt_out 0, cnt_valid 0, timeout 0, busy 0.
REQ-027 Reset asserted in RUN or HOLD SHALL discard any pending result; no cnt_valid follows reset release until a new start/stop.

Configuration
REQ-028 With macro TDC_HALF_CYCLE_EN defined: cnt_out = {counter value, s sampled at the rise edge}, width CNT_W+1; timeout result all ones over CNT_W+1.
REQ-029 Without TDC_HALF_CYCLE_EN: cnt_out = counter value, width CNT_W; s unused.

Structure
REQ-030 Package tdc_pkg SHALL hold the state enum type, CNT_W and MAX_CNT default constants.
REQ-031 Edge detection SHALL be a sub-module tdc_edge_det (sync_d register plus rise output).

Verification
REQ-032 start at edge 0, sync_in high sampled at edge 6, cnt_ready=1 -> cnt_out=5, timeout=0, cnt_valid high one cycle, then IDLE.
REQ-033 MAX_CNT=15, start with no stop -> after 16 RUN edges cnt_valid=1, timeout=1, cnt_out all ones.
REQ-034 cnt_ready=0 for 10 cycles in HOLD, with start and sync_in toggling -> cnt_out/timeout unchanged, state remains HOLD.
REQ-035 start re-asserted at count 3, stop 4 edges later -> cnt_out=3.
REQ-036 TDC_HALF_CYCLE_EN, s=1 at the stop of REQ-032 -> cnt_out=0b1011.
REQ-037 rst_n pulsed low mid-RUN -> all outputs 0 immediately; no cnt_valid after release without a new start.
